irq_ctrl: RTL

Four-source interrupt controller for the single-cycle CPU. It latches rising edges from peripheral interrupt lines, applies a per-source mask and a global enable, and picks the highest-priority pending source. It then asks the control unit to divert the PC to a fixed vector and tracks the service routine until its return. It sits beside the control unit and the PC/return-stack logic; software configures it through an output-port write and reads its status through an input port.

---
 rtl/irq_ctrl_pkg.sv | 21 ++
 rtl/irq_prio_enc.sv | 19 +
 rtl/irq_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the four-source interrupt controller.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam logic CFG_MASK = 1'b0;
  localparam logic CFG_CLR  = 1'b1;

  localparam int GIE_BIT = 7;

  // Field positions within the software-visible status byte
  localparam int STAT_PEND_LSB  = 0;
  localparam int STAT_ID_LSB    = 4;
  localparam int STAT_REQ_BIT   = 6;
  localparam int STAT_INSVC_BIT = 7;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module irq_prio_enc
(
  input  logic [3:0] req,
  output logic [1:0] idx,
  output logic       valid
);

  always_comb begin
    idx   = 2'd0;
    valid = 1'b1;
    if (req[0])      idx = 2'd0;
    else if (req[1]) idx = 2'd1;
    else if (req[2]) idx = 2'd2;
    else if (req[3]) idx = 2'd3;
    else             valid = 1'b0;
  end

endmodule

// File: rtl/irq_ctrl.sv
// Four-source edge-triggered interrupt controller with mask, global enable and service tracking.
// Optional input synchronizer enabled by defining IRQ_CTRL_SYNC_EN.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int               VEC_W      = 10,
  parameter logic [VEC_W-1:0] VEC_BASE   = 10'h3C0,
  parameter int               VEC_STRIDE = 4
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       src_irq,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [7:0]       cfg_data,
  input  logic             irq_ack,
  input  logic             irq_ret,
  output logic             irq_req,
  output logic [VEC_W-1:0] irq_vec,
  output logic [1:0]       irq_id,
  output logic [7:0]       status
);

  logic [3:0] src_s;
  logic [3:0] src_d;
  logic [3:0] src_edge;
  logic [3:0] pending;
  logic [3:0] mask;
  logic       gie;
  logic [3:0] eligible;
  logic [1:0] winner;
  logic       winner_valid;
  logic [3:0] w1c_clr;
  logic [3:0] ack_clr;
  logic       ack_take;
  logic       load_req;
  logic       unused_cfg;

  irq_state_t state, state_nxt;

  assign unused_cfg = ^cfg_data[6:4];

`ifdef IRQ_CTRL_SYNC_EN
  logic [3:0] sync_q1;
  logic [3:0] sync_q2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= src_irq;
      sync_q2 <= sync_q1;
    end
  end

  assign src_s = sync_q2;
`else
  assign src_s = src_irq;
`endif

  assign src_edge = src_s & ~src_d;
  assign eligible = pending & mask & {4{gie}};
  assign ack_take = (state == PEND) && irq_ack;
  assign w1c_clr  = (cfg_we && cfg_sel == CFG_CLR) ? cfg_data[3:0] : 4'b0000;
  assign ack_clr  = ack_take ? (4'b0001 << irq_id) : 4'b0000;

  irq_prio_enc u_prio (
    .req   (eligible),
    .idx   (winner),
    .valid (winner_valid)
  );

  // A fresh edge wins over any clear landing on the same bit, so the source re-pends
  always_ff @(posedge clk) begin
    if (reset) begin
      src_d   <= '0;
      pending <= '0;
      mask    <= '0;
      gie     <= 1'b0;
    end else begin
      src_d   <= src_s;
      pending <= (pending & ~(w1c_clr | ack_clr)) | src_edge;
      if (cfg_we && cfg_sel == CFG_MASK) begin
        mask <= cfg_data[3:0];
        gie  <= cfg_data[GIE_BIT];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_req  = 1'b0;
    case (state)
      IDLE: begin
        if (winner_valid) begin
          state_nxt = PEND;
          load_req  = 1'b1;
        end
      end
      PEND:    if (irq_ack) state_nxt = SERVICE;
      SERVICE: if (irq_ret) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Id and vector are captured once on PEND entry and held until the next request
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_id  <= '0;
      irq_vec <= '0;
    end else if (load_req) begin
      irq_id  <= winner;
      irq_vec <= VEC_BASE + VEC_W'(winner) * VEC_W'(VEC_STRIDE);
    end
  end

  assign irq_req = (state == PEND);

  always_comb begin
    status = '0;
    status[STAT_PEND_LSB +: 4] = pending;
    status[STAT_ID_LSB +: 2]   = irq_id;
    status[STAT_REQ_BIT]       = (state == PEND);
    status[STAT_INSVC_BIT]     = (state == SERVICE);
  end

endmodule
